stream_fifo_level: RTL

// - Single-clock, parametrised-depth stream FIFO with valid/ready on both sides.
// - Provides an optional fall-through mode, a fill-level output, almost-full/empty flags and a synchronous flush.
// - Single-clock successor to cdc_fifo_gray: same handshake, used inside one clock domain for rate decoupling.

---
 rtl/stream_fifo_level_if.sv | 19 +
 rtl/stream_fifo_level.sv | 50 +++++
 2 files changed

// File: rtl/stream_fifo_level_if.sv
// stream_fifo_level_if: valid/ready write and read channels of the stream FIFO.
interface stream_fifo_level_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] src_data_i;
   logic                  src_valid_i;
   logic                  src_ready_o;
   logic [DATA_WIDTH-1:0] dst_data_o;
   logic                  dst_valid_o;
   logic                  dst_ready_i;
   modport slave (
      input  src_data_i, src_valid_i, dst_ready_i,
      output src_ready_o, dst_data_o, dst_valid_o
   );
   modport master (
      output src_data_i, src_valid_i, dst_ready_i,
      input  src_ready_o, dst_data_o, dst_valid_o
   );
endinterface

// File: rtl/stream_fifo_level.sv
// stream_fifo_level: single-clock valid/ready FIFO with fill level, almost flags, flush and optional fall-through.
module stream_fifo_level #(
   parameter int DATA_WIDTH      = 32,
   parameter int LOG_DEPTH       = 3,
   parameter bit FALL_THROUGH    = 1'b0,
   parameter int ALMOST_FULL_TH  = 2**LOG_DEPTH-1,
   parameter int ALMOST_EMPTY_TH = 1
)(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   stream_fifo_level_if.slave   bus,
   output logic [LOG_DEPTH:0]   level_o,
   output logic                 almost_full_o,
   output logic                 almost_empty_o
);
   localparam int DEPTH = 2**LOG_DEPTH;
   localparam logic [LOG_DEPTH:0] AF_TH = (LOG_DEPTH+1)'(ALMOST_FULL_TH);
   localparam logic [LOG_DEPTH:0] AE_TH = (LOG_DEPTH+1)'(ALMOST_EMPTY_TH);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [LOG_DEPTH:0]    r_wr, r_rd;
   logic                  w_empty, w_full, w_push, w_pop, w_bypass, w_wr_en, w_rd_en;
   assign w_empty = r_wr == r_rd;
   assign w_full  = (r_wr[LOG_DEPTH-1:0] == r_rd[LOG_DEPTH-1:0]) && (r_wr[LOG_DEPTH] != r_rd[LOG_DEPTH]);
   assign level_o        = r_wr - r_rd;
   assign almost_full_o  = level_o >= AF_TH;
   assign almost_empty_o = level_o <= AE_TH;
   assign bus.src_ready_o = !w_full;
   assign bus.dst_valid_o = FALL_THROUGH ? (!w_empty || bus.src_valid_i) : !w_empty;
   assign bus.dst_data_o  = (FALL_THROUGH && w_empty) ? bus.src_data_i : r_mem[r_rd[LOG_DEPTH-1:0]];
   assign w_push   = bus.src_valid_i && !w_full;
   assign w_pop    = bus.dst_valid_o && bus.dst_ready_i;
   // a word consumed while passing straight through an empty FIFO never touches storage
   assign w_bypass = FALL_THROUGH && w_empty && w_push && w_pop;
   assign w_wr_en  = w_push && !w_bypass && !flush_i;
   assign w_rd_en  = w_pop && !w_bypass && !flush_i;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_wr <= '0;
         r_rd <= '0;
      end else if (flush_i) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_wr_en) r_wr <= r_wr + 1'b1;
         if (w_rd_en) r_rd <= r_rd + 1'b1;
      end
   always_ff @(posedge clk_i)
      if (w_wr_en) r_mem[r_wr[LOG_DEPTH-1:0]] <= bus.src_data_i;
endmodule
